// File: rtl/sand_brush_painter.sv
// Brush rasteriser: turns one (x, y, radius, type) command into a clipped disc of
// cell writes on an Avalon-style write port, one candidate cell per step.
module sand_brush_painter #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned GRID_W  = 160,
  parameter int unsigned GRID_H  = 120,
  parameter int unsigned TYPE_W  = 2,
  parameter int unsigned ADDR_W  = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [1:0]         cmd_radius,
  input  logic [TYPE_W-1:0]  cmd_type,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [TYPE_W-1:0]  mem_writedata,
  input  logic               mem_waitrequest,
  output logic               busy,
  output logic               done,
  output logic [5:0]         last_count
);

  localparam int unsigned CW = COORD_W + 2;
  localparam logic signed [CW-1:0] GRID_W_S = CW'(GRID_W);
  localparam logic signed [CW-1:0] GRID_H_S = CW'(GRID_H);
  localparam logic [ADDR_W-1:0]    GRID_W_A = ADDR_W'(GRID_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic signed [CW-1:0] r_x, r_y, r_r, r_dx, r_dy;
  logic [TYPE_W-1:0]    r_type;
  logic [5:0]           r_cnt;
  logic [5:0]           r_last_count;
  logic                 r_mem_write;
  logic [ADDR_W-1:0]    r_mem_address;
  logic [TYPE_W-1:0]    r_mem_writedata;

  logic                 w_accept;
  logic                 w_adv;
  logic                 w_last;
  logic signed [CW-1:0] w_ndx, w_ndy;
  logic [5:0]           w_cnt_nxt;

  logic signed [CW-1:0] w_ex, w_ey, w_er, w_edx, w_edy;
  logic signed [CW-1:0] w_cx, w_cy, w_d2, w_r2;
  logic [TYPE_W-1:0]    w_etype;
  logic                 w_in;
  logic [ADDR_W-1:0]    w_addr;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_adv     = (r_state == S_SCAN) && (!r_mem_write || !mem_waitrequest);
  assign w_last    = (r_dx == r_r) && (r_dy == r_r);
  assign w_cnt_nxt = r_cnt + 6'(r_mem_write);

  always_comb begin
    w_ndx = r_dx + CW'(1);
    w_ndy = r_dy;
    if (r_dx == r_r) begin
      w_ndx = -r_r;
      w_ndy = r_dy + CW'(1);
    end
  end

  // Outputs are registered, so the candidate evaluated here is always the one
  // presented next: the first (-r,-r) from the live command while idle, else
  // the successor of the current step.
  always_comb begin
    w_ex    = r_x;
    w_ey    = r_y;
    w_er    = r_r;
    w_edx   = w_ndx;
    w_edy   = w_ndy;
    w_etype = r_type;
    if (r_state == S_IDLE) begin
      w_ex    = $signed({2'b00, cmd_x});
      w_ey    = $signed({2'b00, cmd_y});
      w_er    = $signed({{(CW-2){1'b0}}, cmd_radius});
      w_edx   = -w_er;
      w_edy   = -w_er;
      w_etype = cmd_type;
    end
  end

  assign w_cx   = w_ex + w_edx;
  assign w_cy   = w_ey + w_edy;
  assign w_d2   = (w_edx * w_edx) + (w_edy * w_edy);
  assign w_r2   = w_er * w_er;
  assign w_in   = (w_d2 <= w_r2)
                  && !w_cx[CW-1] && (w_cx < GRID_W_S)
                  && !w_cy[CW-1] && (w_cy < GRID_H_S);
  assign w_addr = (ADDR_W'(w_cy) * GRID_W_A) + ADDR_W'(w_cx);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_adv && w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x             <= '0;
      r_y             <= '0;
      r_r             <= '0;
      r_dx            <= '0;
      r_dy            <= '0;
      r_type          <= '0;
      r_cnt           <= '0;
      r_last_count    <= '0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x             <= w_ex;
            r_y             <= w_ey;
            r_r             <= w_er;
            r_dx            <= w_edx;
            r_dy            <= w_edy;
            r_type          <= w_etype;
            r_cnt           <= '0;
            r_mem_write     <= w_in;
            r_mem_writedata <= w_etype;
            if (w_in) r_mem_address <= w_addr;
          end
        end
        S_SCAN: begin
          // A stalled write leaves every register untouched, which holds the bus.
          if (w_adv) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_mem_write  <= 1'b0;
              r_last_count <= w_cnt_nxt;
            end else begin
              r_dx        <= w_ndx;
              r_dy        <= w_ndy;
              r_mem_write <= w_in;
              if (w_in) r_mem_address <= w_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign last_count    = r_last_count;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;

endmodule

// File: tb/tb_sand_brush_painter.sv
// Directed bench for sand_brush_painter: hand-computed disc address lists,
// edge clipping, stalls, ignored commands and mid-scan reset.
module tb_sand_brush_painter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [1:0]  cmd_radius = '0;
  logic [1:0]  cmd_type = '0;
  logic        mem_write;
  logic [14:0] mem_address;
  logic [1:0]  mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic [5:0]  last_count;

  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  int t_acc = 0;
  int scan_cnt = 0;
  int done_cnt = 0;
  int lat;
  int g;
  int wr_addr[$];
  int wr_data[$];
  int exp_q[$];

  sand_brush_painter #(
    .COORD_W(8), .GRID_W(160), .GRID_H(120), .TYPE_W(2), .ADDR_W(15)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_radius(cmd_radius), .cmd_type(cmd_type),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .busy(busy), .done(done), .last_count(last_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_now++;

  // Writes are recorded mid-cycle; the one seen here is accepted at the next rising edge.
  always @(negedge clock) begin
    if (mem_write && !mem_waitrequest) begin
      wr_addr.push_back(int'(mem_address));
      wr_data.push_back(int'(mem_writedata));
    end
    if (busy && !done) scan_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] r, input logic [1:0] t);
    wr_addr.delete();
    wr_data.delete();
    scan_cnt = 0;
    done_cnt = 0;
    cmd_x = x;
    cmd_y = y;
    cmd_radius = r;
    cmd_type = t;
    cmd_valid = 1'b1;
    tick();
    t_acc = cyc_now;
    cmd_valid = 1'b0;
    cmd_x = 8'hA5;
    cmd_y = 8'h5A;
    cmd_radius = 2'd3;
    cmd_type = ~t;
  endtask

  task automatic wait_done(input string tag, output int lat_o);
    int guard = 0;
    while (!done && guard < 400) begin
      tick();
      guard++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    lat_o = cyc_now - t_acc + 1;
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] t);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_q[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(t));
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last_count", 32'(last_count), 32'd0);
    reset = 1'b0;
    tick();

    // r=0 at (10,20): single cell 20*160+10
    start(8'd10, 8'd20, 2'd0, 2'd2);
    chk("r0_busy", 32'(busy), 32'd1);
    chk("r0_ready_low", 32'(cmd_ready), 32'd0);
    wait_done("r0", lat);
    chk("r0_latency", 32'(lat), 32'd2);
    chk("r0_last_count", 32'(last_count), 32'd1);
    chk("r0_done_mem_write", 32'(mem_write), 32'd0);
    exp_q = '{3210};
    chk_wr("r0", 2'd2);
    tick();
    chk("r0_done_pulse", 32'(done), 32'd0);
    chk("r0_ready_after", 32'(cmd_ready), 32'd1);

    // r=1 plus-shape at (50,50)
    start(8'd50, 8'd50, 2'd1, 2'd1);
    wait_done("r1", lat);
    chk("r1_scan_cycles", 32'(scan_cnt), 32'd9);
    chk("r1_latency", 32'(lat), 32'd10);
    chk("r1_last_count", 32'(last_count), 32'd5);
    exp_q = '{7890, 8049, 8050, 8051, 8210};
    chk_wr("r1", 2'd1);
    tick();

    // r=3 clipped at top-left corner: only the dx,dy >= 0 quadrant survives
    start(8'd0, 8'd0, 2'd3, 2'd3);
    wait_done("tl", lat);
    chk("tl_scan_cycles", 32'(scan_cnt), 32'd49);
    chk("tl_last_count", 32'(last_count), 32'd11);
    exp_q = '{0, 1, 2, 3, 160, 161, 162, 320, 321, 322, 480};
    chk_wr("tl", 2'd3);
    tick();

    // r=3 clipped at bottom-right corner
    start(8'd159, 8'd119, 2'd3, 2'd3);
    wait_done("br", lat);
    chk("br_last_count", 32'(last_count), 32'd11);
    exp_q = '{18719, 18877, 18878, 18879, 19037, 19038, 19039,
              19196, 19197, 19198, 19199};
    chk_wr("br", 2'd3);
    tick();

    // r=2 at (80,60) with a 3-cycle stall on the second write (9519)
    start(8'd80, 8'd60, 2'd2, 2'd1);
    g = 0;
    while (!(mem_write && mem_address == 15'd9519) && g < 50) begin
      tick();
      g++;
    end
    chk("st_second_write_seen", 32'(mem_write && mem_address == 15'd9519), 32'd1);
    mem_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st_hold_wr%0d", k), 32'(mem_write), 32'd1);
      chk($sformatf("st_hold_addr%0d", k), 32'(mem_address), 32'd9519);
      chk($sformatf("st_hold_data%0d", k), 32'(mem_writedata), 32'd1);
    end
    mem_waitrequest = 1'b0;
    wait_done("st", lat);
    chk("st_scan_cycles", 32'(scan_cnt), 32'd28);
    chk("st_latency", 32'(lat), 32'd29);
    chk("st_last_count", 32'(last_count), 32'd13);
    exp_q = '{9360, 9519, 9520, 9521, 9678, 9679, 9680, 9681, 9682,
              9839, 9840, 9841, 10000};
    chk_wr("st", 2'd1);
    tick();

    // a second command offered mid-scan must be dropped
    start(8'd20, 8'd30, 2'd1, 2'd2);
    tick();
    tick();
    tick();
    chk("ig_ready_low", 32'(cmd_ready), 32'd0);
    cmd_x = 8'd100;
    cmd_y = 8'd100;
    cmd_radius = 2'd3;
    cmd_type = 2'd3;
    cmd_valid = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    wait_done("ig", lat);
    chk("ig_last_count", 32'(last_count), 32'd5);
    exp_q = '{4660, 4819, 4820, 4821, 4980};
    chk_wr("ig", 2'd2);
    tick();
    chk("ig_idle_after", 32'(busy), 32'd0);

    // reset in the middle of an r=3 scan
    start(8'd80, 8'd60, 2'd3, 2'd1);
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    tick();
    chk("rs_mem_write", 32'(mem_write), 32'd0);
    chk("rs_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rs_last_count", 32'(last_count), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    chk("rs_no_done_pulse", 32'(done_cnt), 32'd0);

    // eraser (type 0) r=0 after the aborted command
    start(8'd5, 8'd5, 2'd0, 2'd0);
    wait_done("er", lat);
    chk("er_latency", 32'(lat), 32'd2);
    chk("er_last_count", 32'(last_count), 32'd1);
    exp_q = '{805};
    chk_wr("er", 2'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc_now);
    $fatal(1, "bench timeout");
  end

endmodule
